ndro_bank_sequencer: RTL

Synchronous controller that sequences a bank of NDRO storage cells (set / reset / clk pulse inputs, out / resout pulse outputs).
- Accepts one request at a time: SET, CLR or READ, with a cell address.
- Drives the pulse lines and enforces each cell's critical-timing windows as cycle guards, so cell-level timing violations cannot occur.
- Checks returned pulses against a shadow copy of each cell's state.
- Sits between the bank's host logic and the cell array.

---
 rtl/ndro_bank_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ndro_bank_sequencer.sv
// Request sequencer for a bank of NDRO cells: issues toggle-encoded set/reset/clk pulses,
// holds per-cell timing guards, and checks returned out/resout pulses against a shadow state.
module ndro_bank_sequencer #(
  parameter int N_CELLS    = 4,
  parameter int AW         = 2,
  parameter int CT_RST_SET = 2,
  parameter int CT_RST_CLK = 1,
  parameter int CT_CLK_RST = 2,
  parameter int CT_CLK_CLK = 3,
  parameter int RD_LAT     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [AW-1:0]      req_addr,
  output logic               rsp_valid,
  output logic               rsp_data,
  output logic               rsp_err,
  output logic [N_CELLS-1:0] cell_set,
  output logic [N_CELLS-1:0] cell_reset,
  output logic [N_CELLS-1:0] cell_clk,
  input  logic [N_CELLS-1:0] cell_out,
  input  logic [N_CELLS-1:0] cell_resout,
  output logic               busy
);

  localparam int GW = 8;
  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, RESP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [GW-1:0]        lat_q, lat_d;
  logic                 latched_q, latched_d;
  logic                 old_sh_q, old_sh_d;
  logic                 data_q, data_d;
  logic                 err_q, err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [N_CELLS-1:0]   shadow_q, shadow_d;
  logic [N_CELLS-1:0]   set_line_q, set_line_d;
  logic [N_CELLS-1:0]   rst_line_q, rst_line_d;
  logic [N_CELLS-1:0]   clk_line_q, clk_line_d;
  logic [N_CELLS-1:0]   set_free, rst_free, clk_free;
  logic                 guard_free, issue, sampled, tog;

  function automatic logic [GW-1:0] arm_max(input logic [GW-1:0] cur, input int ct);
    logic [GW-1:0] ctv;
    ctv = GW'(ct);
    return (cur > ctv) ? cur : ctv;
  endfunction

  // Guards count down freely; an arm on the same edge overrides the decrement.
  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    logic [GW-1:0] set_g_q, set_g_d, rst_g_q, rst_g_d, clk_g_q, clk_g_d;
    logic          hit;

    assign hit = issue && (32'(addr_q) == gi);

    always_comb begin
      set_g_d = (set_g_q != '0) ? set_g_q - GW'(1) : set_g_q;
      rst_g_d = (rst_g_q != '0) ? rst_g_q - GW'(1) : rst_g_q;
      clk_g_d = (clk_g_q != '0) ? clk_g_q - GW'(1) : clk_g_q;
      if (hit && op_q == OP_CLR) begin
        set_g_d = arm_max(set_g_q, CT_RST_SET);
        if (shadow_q[gi]) clk_g_d = arm_max(clk_g_q, CT_RST_CLK);
      end
      if (hit && op_q == OP_READ && shadow_q[gi]) begin
        rst_g_d = arm_max(rst_g_q, CT_CLK_RST);
        clk_g_d = arm_max(clk_g_q, CT_CLK_CLK);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        set_g_q <= '0;
        rst_g_q <= '0;
        clk_g_q <= '0;
      end else begin
        set_g_q <= set_g_d;
        rst_g_q <= rst_g_d;
        clk_g_q <= clk_g_d;
      end
    end

    assign set_free[gi] = (set_g_q == '0);
    assign rst_free[gi] = (rst_g_q == '0);
    assign clk_free[gi] = (clk_g_q == '0);
  end

  always_comb begin
    case (op_q)
      OP_SET:  guard_free = set_free[addr_q];
      OP_CLR:  guard_free = rst_free[addr_q];
      default: guard_free = clk_free[addr_q];
    endcase
  end

  assign issue   = (state_q == WAIT) && guard_free;
  assign sampled = (op_q == OP_CLR) ? cell_resout[addr_q] : cell_out[addr_q];
  assign tog     = sampled ^ latched_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    lat_d       = lat_q;
    latched_d   = latched_q;
    old_sh_d    = old_sh_q;
    data_d      = data_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    shadow_d    = shadow_q;
    set_line_d  = set_line_q;
    rst_line_d  = rst_line_q;
    clk_line_d  = clk_line_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          addr_d = req_addr;
          data_d = 1'b0;
          err_d  = 1'b0;
          if (req_op == 2'b11 || 32'(req_addr) >= N_CELLS) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (guard_free) begin
          old_sh_d = shadow_q[addr_q];
          lat_d    = GW'(RD_LAT);
          case (op_q)
            OP_SET: begin
              set_line_d[addr_q] = ~set_line_q[addr_q];
              shadow_d[addr_q]   = 1'b1;
              state_d            = RESP;
            end
            OP_CLR: begin
              rst_line_d[addr_q] = ~rst_line_q[addr_q];
              latched_d          = cell_resout[addr_q];
              shadow_d[addr_q]   = 1'b0;
              state_d            = SETTLE;
            end
            default: begin
              clk_line_d[addr_q] = ~clk_line_q[addr_q];
              latched_d          = cell_out[addr_q];
              state_d            = SETTLE;
            end
          endcase
        end
      end
      SETTLE: begin
        if (lat_q > GW'(1)) begin
          lat_d = lat_q - GW'(1);
        end else begin
          err_d   = (tog != old_sh_q);
          data_d  = (op_q == OP_READ) && tog;
          state_d = RESP;
        end
      end
      default: begin
        // First RESP cycle raises the strobe, second returns to IDLE.
        if (!rsp_valid_q) rsp_valid_d = 1'b1;
        else              state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      addr_q      <= '0;
      lat_q       <= '0;
      latched_q   <= 1'b0;
      old_sh_q    <= 1'b0;
      data_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      shadow_q    <= '0;
      set_line_q  <= '0;
      rst_line_q  <= '0;
      clk_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      latched_q   <= latched_d;
      old_sh_q    <= old_sh_d;
      data_q      <= data_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      shadow_q    <= shadow_d;
      set_line_q  <= set_line_d;
      rst_line_q  <= rst_line_d;
      clk_line_q  <= clk_line_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_valid_q & data_q;
  assign rsp_err    = rsp_valid_q & err_q;
  assign cell_set   = set_line_q;
  assign cell_reset = rst_line_q;
  assign cell_clk   = clk_line_q;

endmodule
